up3_ctrl: RTL and testbench
===========================

UP3_CTRL -- requirements
Module: up3_ctrl

Interface
REQ-001 The block SHALL have parameter: COUNT_W, 8, width of the retired-instruction counter.
REQ-002 The block SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 The block SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port: run  input  1  level; free-run instructions while high.
REQ-005 The block SHALL have port: step  input  1  level; each rising edge requests exactly one instruction.
REQ-006 The block SHALL have port: opcode  input  8  upper instruction register from datapath.
REQ-007 The block SHALL have port: ac_zero  input  1  datapath AC == 0.
REQ-008 The block SHALL have port: STATE  output  3  current state encoding.
REQ-009 The block SHALL have ports: FETCH, LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, LOAD_AC, STORE_MEM  output  1 each  datapath strobes.
REQ-010 The block SHALL have port: ac_src  output  2  AC input select: 00 IR value, 01 MDR, 10 adder (AC+MDR).
REQ-011 The block SHALL have port: addr_src  output  1  memory address select: 0 PC, 1 IR address.
REQ-012 The block SHALL have ports: halted  output  1; illegal  output  1 (sticky); instr_count  output  COUNT_W.

Function
REQ-013 States SHALL be: IDLE=0, FETCH_U=1, DECODE=2, FETCH_L=3, EXEC=4, STORE=5, HALT=6; 7 is unreachable and SHALL map to IDLE.
REQ-014 Opcodes SHALL be: 00 NOP, 01 LDI, 02 LDM, 03 STM, 04 ADD, 05 JMP, 06 JNZ, FF HLT; all others SHALL be illegal.
REQ-015 IDLE: all strobes 0; go to FETCH_U if run=1 or a step rising edge is detected; otherwise stay in IDLE.
REQ-016 FETCH_U: FETCH=1, LOAD_IRU=1, INCR_PC=1, addr_src=0; next state DECODE.
REQ-017 DECODE: no strobes; NOP/illegal -> EXEC; HLT -> HALT; all other opcodes -> FETCH_L.
REQ-018 FETCH_L: FETCH=1, LOAD_IRL=1, INCR_PC=1, addr_src=0; next state EXEC.
REQ-019 EXEC strobes, one cycle: LDI -> LOAD_AC with ac_src=00; LDM -> LOAD_AC with ac_src=01, addr_src=1; ADD -> LOAD_AC with ac_src=10, addr_src=1; JMP -> LOAD_PC=1; JNZ -> LOAD_PC=~ac_zero; STM -> addr_src=1, no strobe; NOP/illegal -> none.
REQ-020 Transitions out of EXEC: STM -> STORE; otherwise -> FETCH_U if run=1, else IDLE.
REQ-021 STORE: STORE_MEM=1, addr_src=1; next state FETCH_U if run=1, else IDLE.
REQ-022 Instruction length SHALL be: NOP/illegal 3 cycles; LDI/LDM/ADD/JMP/JNZ 4 cycles; STM 5 cycles (FETCH_U to last state).
REQ-023 Memory read data SHALL be treated as combinational from address; no wait states.
REQ-024 Step edge: step_q SHALL be a register; edge = step & ~step_q; edges outside IDLE SHALL be discarded, not queued.
REQ-025 run dropping mid-instruction SHALL complete the current instruction, then enter IDLE.
REQ-026 HALT: halted=1, all strobes 0; run and step SHALL be ignored; exit only by reset.
REQ-027 illegal SHALL set in DECODE on an illegal opcode and remain set until reset.
REQ-028 instr_count SHALL increment by 1 on leaving EXEC to any state but STORE, on leaving STORE, and on entering HALT; it SHALL wrap modulo 2^COUNT_W.
REQ-029 All strobe outputs SHALL be combinational from registered state and opcode, with no dependence on run or step.

Reset
REQ-030 reset SHALL take priority over all other inputs in any state: STATE=IDLE, halted=0, illegal=0, instr_count=0, all strobes 0, ac_src=00, addr_src=0.
REQ-031 Reset SHALL set step_q=1, so a step held high across reset release SHALL NOT trigger an instruction.

Structure
REQ-032 Package up3_pkg SHALL hold: the state enum (3-bit), opcode constants, and ac_src encodings; this package is shared with the datapath.
REQ-033 The FSM and edge detector SHALL be a single module with no sub-modules; next-state logic and output decode SHALL be separate processes.

Verification
REQ-034 Reset, then run=1, opcode=01: states 1,2,3,4 repeat; LOAD_IRL in cycle 3; LOAD_AC with ac_src=00 in cycle 4; instr_count=1 after cycle 4.
REQ-035 opcode=03 with run=1: STORE_MEM=1 with addr_src=1 exactly once, in cycle 5, and never in EXEC.
REQ-036 opcode=06: with ac_zero=1, LOAD_PC stays 0 in EXEC; with ac_zero=0, LOAD_PC=1 in EXEC.
REQ-037 run=0, step pulse high 10 cycles: exactly one instruction, then IDLE; a second step edge during an instruction is ignored.
REQ-038 opcode=7A: illegal=1 from DECODE onward, NOP timing applies; then opcode=FF: HALT, halted=1; run is ignored for 20 cycles; reset clears to IDLE with all flags 0.

Source files
------------

// File: rtl/up3_pkg.sv
// Shared definitions for the UP3 controller and its datapath: state
// encoding, opcode values and AC input-select codes.
package up3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_U = 3'd1,
    ST_DECODE  = 3'd2,
    ST_FETCH_L = 3'd3,
    ST_EXEC    = 3'd4,
    ST_STORE   = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_LDM = 8'h02;
  localparam logic [7:0] OP_STM = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h04;
  localparam logic [7:0] OP_JMP = 8'h05;
  localparam logic [7:0] OP_JNZ = 8'h06;
  localparam logic [7:0] OP_HLT = 8'hFF;

  localparam logic [1:0] AC_SRC_IR  = 2'b00;
  localparam logic [1:0] AC_SRC_MDR = 2'b01;
  localparam logic [1:0] AC_SRC_ADD = 2'b10;

  // Anything outside the defined opcode set is treated as illegal and
  // executes with NOP timing.
  function automatic logic isIllegalOp(input logic [7:0] op);
    logic legal;
    legal = (op <= OP_JNZ) || (op == OP_HLT);
    return !legal;
  endfunction

endpackage

// File: rtl/up3_ctrl.sv
// UP3 control unit: sequences fetch/decode/execute for the UP3 datapath,
// detects step edges, tracks the sticky illegal flag and counts retired
// instructions.
module up3_ctrl
  import up3_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic [7:0]         opcode,
  input  logic               ac_zero,
  output logic [2:0]         STATE,
  output logic               FETCH,
  output logic               LOAD_IRU,
  output logic               LOAD_IRL,
  output logic               LOAD_PC,
  output logic               INCR_PC,
  output logic               LOAD_AC,
  output logic               STORE_MEM,
  output logic [1:0]         ac_src,
  output logic               addr_src,
  output logic               halted,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  state_t             r_state;
  state_t             w_nextState;
  logic               r_stepQ;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_count;
  logic               w_stepEdge;
  logic               w_retire;

  // A step request is only a low-to-high transition; step_q resets high so a
  // step held across reset release is not mistaken for a new request.
  assign w_stepEdge = step & ~r_stepQ;

  // An instruction retires when EXEC finishes (unless a store follows), when
  // STORE finishes, or when a HLT moves the machine into HALT.
  assign w_retire = ((r_state == ST_EXEC) && (w_nextState != ST_STORE)) ||
                    (r_state == ST_STORE) ||
                    ((r_state != ST_HALT) && (w_nextState == ST_HALT));

  assign STATE       = r_state;
  assign halted      = (r_state == ST_HALT);
  assign illegal     = r_illegal;
  assign instr_count = r_count;

  // State register and step history; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_stepQ <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_stepQ <= step;
    end
  end

  // Sticky illegal flag set when an undefined opcode is decoded, and the
  // wrapping retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      if ((r_state == ST_DECODE) && isIllegalOp(opcode)) begin
        r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  // Next-state sequencing; step edges seen outside IDLE are simply dropped,
  // and a run that falls mid-instruction lets the instruction finish first.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (run || w_stepEdge) begin
          w_nextState = ST_FETCH_U;
        end
      end
      ST_FETCH_U: w_nextState = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OP_HLT) begin
          w_nextState = ST_HALT;
        end else if ((opcode == OP_NOP) || isIllegalOp(opcode)) begin
          w_nextState = ST_EXEC;
        end else begin
          w_nextState = ST_FETCH_L;
        end
      end
      ST_FETCH_L: w_nextState = ST_EXEC;
      ST_EXEC: begin
        if (opcode == OP_STM) begin
          w_nextState = ST_STORE;
        end else begin
          w_nextState = run ? ST_FETCH_U : ST_IDLE;
        end
      end
      ST_STORE: w_nextState = run ? ST_FETCH_U : ST_IDLE;
      ST_HALT:  w_nextState = ST_HALT;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded purely from the registered state and opcode.
  always_comb begin
    FETCH     = 1'b0;
    LOAD_IRU  = 1'b0;
    LOAD_IRL  = 1'b0;
    LOAD_PC   = 1'b0;
    INCR_PC   = 1'b0;
    LOAD_AC   = 1'b0;
    STORE_MEM = 1'b0;
    ac_src    = AC_SRC_IR;
    addr_src  = 1'b0;
    case (r_state)
      ST_FETCH_U: begin
        FETCH    = 1'b1;
        LOAD_IRU = 1'b1;
        INCR_PC  = 1'b1;
      end
      ST_FETCH_L: begin
        FETCH    = 1'b1;
        LOAD_IRL = 1'b1;
        INCR_PC  = 1'b1;
      end
      ST_EXEC: begin
        case (opcode)
          OP_LDI: begin
            LOAD_AC = 1'b1;
            ac_src  = AC_SRC_IR;
          end
          OP_LDM: begin
            LOAD_AC  = 1'b1;
            ac_src   = AC_SRC_MDR;
            addr_src = 1'b1;
          end
          OP_ADD: begin
            LOAD_AC  = 1'b1;
            ac_src   = AC_SRC_ADD;
            addr_src = 1'b1;
          end
          OP_JMP:  LOAD_PC  = 1'b1;
          OP_JNZ:  LOAD_PC  = ~ac_zero;
          OP_STM:  addr_src = 1'b1;
          default: ;
        endcase
      end
      ST_STORE: begin
        STORE_MEM = 1'b1;
        addr_src  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_up3_ctrl.sv
// Directed testbench for up3_ctrl: walks LDI, STM, JNZ, ADD, stepping,
// illegal opcode, HALT and reset behaviour with hand-computed expectations.
module tb_up3_ctrl;

  logic       clk;
  logic       reset;
  logic       run;
  logic       step;
  logic [7:0] opcode;
  logic       acZero;
  logic [2:0] stateOut;
  logic       fetch, loadIru, loadIrl, loadPc, incrPc, loadAc, storeMem;
  logic [1:0] acSrc;
  logic       addrSrc;
  logic       halted;
  logic       illegal;
  logic [7:0] instrCount;
  logic [6:0] strobes;

  int checks = 0;
  int errors = 0;

  // Strobe bit order: FETCH, LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, LOAD_AC, STORE_MEM
  localparam logic [6:0] S_NONE   = 7'b0000000;
  localparam logic [6:0] S_FETCHU = 7'b1100100;
  localparam logic [6:0] S_FETCHL = 7'b1010100;
  localparam logic [6:0] S_LOADPC = 7'b0001000;
  localparam logic [6:0] S_LOADAC = 7'b0000010;
  localparam logic [6:0] S_STORE  = 7'b0000001;

  assign strobes = {fetch, loadIru, loadIrl, loadPc, incrPc, loadAc, storeMem};

  up3_ctrl #(.COUNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .opcode     (opcode),
    .ac_zero    (acZero),
    .STATE      (stateOut),
    .FETCH      (fetch),
    .LOAD_IRU   (loadIru),
    .LOAD_IRL   (loadIrl),
    .LOAD_PC    (loadPc),
    .INCR_PC    (incrPc),
    .LOAD_AC    (loadAc),
    .STORE_MEM  (storeMem),
    .ac_src     (acSrc),
    .addr_src   (addrSrc),
    .halted     (halted),
    .illegal    (illegal),
    .instr_count(instrCount)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs on the falling edge, then advance one full cycle so that
  // outputs are observed at the next falling edge.
  task automatic applyStimulus(input logic rst, input logic rn, input logic stp,
                               input logic [7:0] op, input logic az);
    reset  = rst;
    run    = rn;
    step   = stp;
    opcode = op;
    acZero = az;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence.
  initial begin
    reset  = 1'b1;
    run    = 1'b0;
    step   = 1'b0;
    opcode = 8'h00;
    acZero = 1'b0;
    @(negedge clk);

    // Reset with run high must still hold IDLE.
    applyStimulus(1, 1, 0, 8'h01, 0);
    applyStimulus(1, 1, 0, 8'h01, 0);
    checkOutput("rst_state", stateOut, 3'd0);
    checkOutput("rst_strobes", strobes, S_NONE);
    checkOutput("rst_acsrc", acSrc, 2'b00);
    checkOutput("rst_addrsrc", addrSrc, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_illegal", illegal, 1'b0);
    checkOutput("rst_count", instrCount, 8'd0);

    // LDI under run: states 1,2,3,4 then back to 1.
    applyStimulus(0, 1, 0, 8'h01, 0);
    checkOutput("ldi_c1_state", stateOut, 3'd1);
    checkOutput("ldi_c1_strobes", strobes, S_FETCHU);
    checkOutput("ldi_c1_addrsrc", addrSrc, 1'b0);
    applyStimulus(0, 1, 0, 8'h01, 0);
    checkOutput("ldi_c2_state", stateOut, 3'd2);
    checkOutput("ldi_c2_strobes", strobes, S_NONE);
    applyStimulus(0, 1, 0, 8'h01, 0);
    checkOutput("ldi_c3_state", stateOut, 3'd3);
    checkOutput("ldi_c3_strobes", strobes, S_FETCHL);
    applyStimulus(0, 1, 0, 8'h01, 0);
    checkOutput("ldi_c4_state", stateOut, 3'd4);
    checkOutput("ldi_c4_strobes", strobes, S_LOADAC);
    checkOutput("ldi_c4_acsrc", acSrc, 2'b00);
    checkOutput("ldi_c4_count", instrCount, 8'd0);
    applyStimulus(0, 1, 0, 8'h01, 0);
    checkOutput("ldi_next_state", stateOut, 3'd1);
    checkOutput("ldi_count", instrCount, 8'd1);

    // STM: store strobe only in the fifth cycle.
    applyStimulus(0, 1, 0, 8'h03, 0);
    checkOutput("stm_c2_state", stateOut, 3'd2);
    applyStimulus(0, 1, 0, 8'h03, 0);
    checkOutput("stm_c3_state", stateOut, 3'd3);
    applyStimulus(0, 1, 0, 8'h03, 0);
    checkOutput("stm_c4_state", stateOut, 3'd4);
    checkOutput("stm_c4_strobes", strobes, S_NONE);
    checkOutput("stm_c4_addrsrc", addrSrc, 1'b1);
    applyStimulus(0, 1, 0, 8'h03, 0);
    checkOutput("stm_c5_state", stateOut, 3'd5);
    checkOutput("stm_c5_strobes", strobes, S_STORE);
    checkOutput("stm_c5_addrsrc", addrSrc, 1'b1);
    checkOutput("stm_c5_count", instrCount, 8'd1);
    applyStimulus(0, 1, 0, 8'h03, 0);
    checkOutput("stm_next_state", stateOut, 3'd1);
    checkOutput("stm_next_strobes", strobes, S_FETCHU);
    checkOutput("stm_count", instrCount, 8'd2);

    // JNZ: LOAD_PC follows ~ac_zero in EXEC; run drops so IDLE follows.
    applyStimulus(0, 1, 0, 8'h06, 1);
    applyStimulus(0, 1, 0, 8'h06, 1);
    applyStimulus(0, 1, 0, 8'h06, 1);
    checkOutput("jnz_exec_state", stateOut, 3'd4);
    checkOutput("jnz_z1_strobes", strobes, S_NONE);
    acZero = 1'b0;
    #1;
    checkOutput("jnz_z0_strobes", strobes, S_LOADPC);
    applyStimulus(0, 0, 0, 8'h06, 0);
    checkOutput("jnz_idle_state", stateOut, 3'd0);
    checkOutput("jnz_count", instrCount, 8'd3);

    // Step held high for 10 cycles with ADD: exactly one instruction.
    applyStimulus(0, 0, 0, 8'h04, 0);
    checkOutput("idle_hold_state", stateOut, 3'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, 8'h04, 0);
      if (i == 0) checkOutput("step_c1_state", stateOut, 3'd1);
      if (i == 3) begin
        checkOutput("add_exec_strobes", strobes, S_LOADAC);
        checkOutput("add_exec_acsrc", acSrc, 2'b10);
        checkOutput("add_exec_addrsrc", addrSrc, 1'b1);
      end
      if (i == 4) checkOutput("step_done_state", stateOut, 3'd0);
    end
    checkOutput("step_hold_state", stateOut, 3'd0);
    checkOutput("step_hold_count", instrCount, 8'd4);

    // Second edge arriving mid-instruction is discarded.
    applyStimulus(0, 0, 0, 8'h04, 0);
    applyStimulus(0, 0, 1, 8'h04, 0);
    checkOutput("step2_state", stateOut, 3'd1);
    applyStimulus(0, 0, 0, 8'h04, 0);
    applyStimulus(0, 0, 1, 8'h04, 0);
    checkOutput("step2_fetchl_state", stateOut, 3'd3);
    applyStimulus(0, 0, 1, 8'h04, 0);
    applyStimulus(0, 0, 1, 8'h04, 0);
    checkOutput("step2_idle_state", stateOut, 3'd0);
    applyStimulus(0, 0, 1, 8'h04, 0);
    checkOutput("step2_noqueue_state", stateOut, 3'd0);
    checkOutput("step2_count", instrCount, 8'd5);

    // Illegal opcode: NOP timing, sticky flag.
    applyStimulus(0, 1, 0, 8'h7A, 0);
    checkOutput("ill_c1_state", stateOut, 3'd1);
    applyStimulus(0, 1, 0, 8'h7A, 0);
    checkOutput("ill_c2_state", stateOut, 3'd2);
    applyStimulus(0, 1, 0, 8'h7A, 0);
    checkOutput("ill_c3_state", stateOut, 3'd4);
    checkOutput("ill_c3_strobes", strobes, S_NONE);
    checkOutput("ill_flag", illegal, 1'b1);
    applyStimulus(0, 1, 0, 8'h7A, 0);
    checkOutput("ill_next_state", stateOut, 3'd1);
    checkOutput("ill_count", instrCount, 8'd6);

    // HLT: HALT entered after DECODE, counted, and then inputs ignored.
    applyStimulus(0, 1, 0, 8'hFF, 0);
    checkOutput("hlt_decode_state", stateOut, 3'd2);
    applyStimulus(0, 1, 0, 8'hFF, 0);
    checkOutput("hlt_state", stateOut, 3'd6);
    checkOutput("hlt_halted", halted, 1'b1);
    checkOutput("hlt_strobes", strobes, S_NONE);
    checkOutput("hlt_count", instrCount, 8'd7);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, i[0], 8'h01, 0);
    end
    checkOutput("hlt_hold_state", stateOut, 3'd6);
    checkOutput("hlt_hold_count", instrCount, 8'd7);
    checkOutput("hlt_hold_illegal", illegal, 1'b1);

    // Reset clears everything; step held across release does not start.
    applyStimulus(1, 1, 1, 8'h01, 0);
    checkOutput("rst2_state", stateOut, 3'd0);
    checkOutput("rst2_halted", halted, 1'b0);
    checkOutput("rst2_illegal", illegal, 1'b0);
    checkOutput("rst2_count", instrCount, 8'd0);
    checkOutput("rst2_strobes", strobes, S_NONE);
    applyStimulus(0, 0, 1, 8'h01, 0);
    applyStimulus(0, 0, 1, 8'h01, 0);
    checkOutput("rst2_stephold_state", stateOut, 3'd0);
    applyStimulus(0, 0, 0, 8'h01, 0);
    applyStimulus(0, 0, 1, 8'h01, 0);
    checkOutput("rst2_newedge_state", stateOut, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
